ring_token_arbiter: RTL

Token-ring arbiter that shares a single access token among `N` requesting ring nodes. It models lossy token transit, timeout-based token regeneration, bounded hold time and per-node starvation detection. It is the scheduler sitting above the ring-request benchmarks: the tester drives `req`/`loss`/`release` and watches `error` (safety violation) and `objective` (goal reached).

---
 rtl/ring_arb_pkg.sv | 23 ++
 rtl/ring_starve_mon.sv | 45 ++++
 rtl/ring_token_arbiter.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/ring_arb_pkg.sv
// Shared definitions for the token-ring arbiter.
// Holds the FSM state encoding, the default parameter values and the
// counter-width helper.
package ring_arb_pkg;

    typedef enum logic [1:0] {
        S_INIT = 2'd0,
        S_PASS = 2'd1,
        S_HELD = 2'd2,
        S_LOST = 2'd3
    } state_e;

    localparam int unsigned DEF_N          = 4;
    localparam int unsigned DEF_TIMEOUT    = 6;
    localparam int unsigned DEF_HOLD_MAX   = 3;
    localparam int unsigned DEF_STARVE_MAX = 12;

    // Bits needed to hold values 0..max_val (at least one bit).
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/ring_starve_mon.sv
// Per-node starvation monitor: saturating count of cycles spent requesting
// without a grant.
// Ports:
//   clk, reset : clock and synchronous active-high reset
//   req        : node request level
//   grant      : node grant (registered, from the arbiter)
//   at_max     : registered flag, counter sits at STARVE_MAX
module ring_starve_mon
    import ring_arb_pkg::*;
#(
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic grant,
    output logic at_max
);

    localparam int unsigned CNT_W = cnt_width(STARVE_MAX);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_next;

    // Clear when not waiting, otherwise count up and saturate.
    always_comb begin
        cnt_next = cnt;
        if (!req || grant) begin
            cnt_next = '0;
        end else if (cnt != CNT_W'(STARVE_MAX)) begin
            cnt_next = cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt    <= '0;
            at_max <= 1'b0;
        end else begin
            cnt    <= cnt_next;
            at_max <= (cnt_next == CNT_W'(STARVE_MAX));
        end
    end

endmodule

// File: rtl/ring_token_arbiter.sv
// Token-ring arbiter: one token circulates among N nodes, may be lost in
// transit, is held for a bounded time, and (optionally) is regenerated
// after a timeout. Tracks starvation (error) and full coverage (objective).
// Build option: define RING_ARB_REGEN_EN to regenerate a lost token after
// TIMEOUT cycles; without it LOST is absorbing until reset.
// Ports:
//   clk, reset    : clock and synchronous active-high reset
//   req[N]        : per-node request level
//   loss          : token dropped in transit (sampled in PASS)
//   early_release : holder returns the token early (sampled in HELD)
//   grant[N]      : one-hot or zero grant
//   token_valid   : token exists (PASS or HELD)
//   holder        : current token position
//   error         : sticky starvation flag
//   objective     : sticky, every node granted at least once since reset
module ring_token_arbiter
    import ring_arb_pkg::*;
#(
    parameter int unsigned N          = DEF_N,
    parameter int unsigned TIMEOUT    = DEF_TIMEOUT,
    parameter int unsigned HOLD_MAX   = DEF_HOLD_MAX,
    parameter int unsigned STARVE_MAX = DEF_STARVE_MAX
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    input  logic                 loss,
    input  logic                 early_release,
    output logic [N-1:0]         grant,
    output logic                 token_valid,
    output logic [$clog2(N)-1:0] holder,
    output logic                 error,
    output logic                 objective
);

    localparam int unsigned HOLDER_W = $clog2(N);
    localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

    // Elaboration-time guard on the parameter ranges.
    if (N < 2 || TIMEOUT < 1 || HOLD_MAX < 1 || STARVE_MAX < 1) begin : g_bad_params
        $error("ring_token_arbiter: N must be >= 2 and all limits >= 1");
    end

    state_e              state;
    logic [HOLD_W-1:0]   hold_cnt;
    logic [N-1:0]        served;
    logic [N-1:0]        at_max;
    logic [HOLDER_W-1:0] holder_next;

    // Ring successor of the current holder; N need not be a power of two.
    always_comb begin
        holder_next = holder + HOLDER_W'(1);
        if (holder == HOLDER_W'(N - 1)) begin
            holder_next = '0;
        end
    end

    for (genvar i = 0; i < N; i++) begin : g_starve
        ring_starve_mon #(
            .STARVE_MAX (STARVE_MAX)
        ) u_mon (
            .clk    (clk),
            .reset  (reset),
            .req    (req[i]),
            .grant  (grant[i]),
            .at_max (at_max[i])
        );
    end

`ifdef RING_ARB_REGEN_EN
    localparam int unsigned TIMER_W = cnt_width(TIMEOUT);
    logic [TIMER_W-1:0] timer;
`endif

    // Token FSM with registered outputs plus sticky status flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_INIT;
            holder      <= '0;
            grant       <= '0;
            token_valid <= 1'b0;
            hold_cnt    <= '0;
            served      <= '0;
            error       <= 1'b0;
            objective   <= 1'b0;
`ifdef RING_ARB_REGEN_EN
            timer       <= '0;
`endif
        end else begin
            served    <= served | grant;
            objective <= &(served | grant);
            error     <= error | (|at_max);

            case (state)
                S_INIT: begin
                    state       <= S_PASS;
                    holder      <= '0;
                    token_valid <= 1'b1;
                end
                S_PASS: begin
                    if (loss) begin
                        state       <= S_LOST;
                        token_valid <= 1'b0;
`ifdef RING_ARB_REGEN_EN
                        timer       <= '0;
`endif
                    end else if (req[holder]) begin
                        state    <= S_HELD;
                        hold_cnt <= '0;
                        grant    <= N'(1) << holder;
                    end else begin
                        holder <= holder_next;
                    end
                end
                S_HELD: begin
                    // Early release and hold expiry leave identically.
                    if (early_release || hold_cnt == HOLD_W'(HOLD_MAX - 1)) begin
                        state  <= S_PASS;
                        holder <= holder_next;
                        grant  <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HOLD_W'(1);
                    end
                end
                S_LOST: begin
`ifdef RING_ARB_REGEN_EN
                    if (timer == TIMER_W'(TIMEOUT - 1)) begin
                        state       <= S_PASS;
                        holder      <= '0;
                        token_valid <= 1'b1;
                    end else begin
                        timer <= timer + TIMER_W'(1);
                    end
`else
                    state <= S_LOST;
`endif
                end
                default: state <= S_INIT;
            endcase
        end
    end

endmodule
